// File: rtl/cond_accum_pkg.sv
// cond_accum_pkg: FSM encoding and saturation limits shared by cond_accum and sat_add.
package cond_accum_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_e;
  localparam int LIM_W = 64;
  function automatic logic [LIM_W-1:0] sat_limit(input int w, input logic neg);
    logic [LIM_W-1:0] m;
    m = (LIM_W'(1) << (w - 1)) - LIM_W'(1);
    return neg ? ~m : m;
  endfunction
endpackage

// File: rtl/sat_add.sv
// sat_add: signed adder that either clamps to the signed range or wraps modulo 2^DATA_W.
module sat_add
  import cond_accum_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sat_en_i,
  output logic [DATA_W-1:0] sum_o
);
  localparam logic [LIM_W-1:0] MAX_L = sat_limit(DATA_W, 1'b0);
  localparam logic [LIM_W-1:0] MIN_L = sat_limit(DATA_W, 1'b1);
  logic [DATA_W-1:0] raw;
  logic              ovf;
  assign raw = a_i + b_i;
  // Overflow only when both operands share a sign that the result lost.
  assign ovf = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (raw[DATA_W-1] != a_i[DATA_W-1]);
  assign sum_o = (sat_en_i && ovf) ? (a_i[DATA_W-1] ? MIN_L[DATA_W-1:0] : MAX_L[DATA_W-1:0]) : raw;
endmodule

// File: rtl/cond_accum.sv
// cond_accum: conditional signed accumulator with start delay, windowing and a window-done pulse.
module cond_accum
  import cond_accum_pkg::*;
#(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  input  logic [31:0]        in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [15:0]        period,
  input  logic               sat_en,
  output logic [DATA_W-1:0]  out0,
  output logic [15:0]        out1,
  output logic               valid
);
  state_e             state_q, state_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [DATA_W-1:0]  acc_q, acc_d, base_acc, sum;
  logic [15:0]        cnt_q, cnt_d, base_cnt, win_q, win_d;
  logic               clr_q, clr_d, valid_q, valid_d, take, win_end;
  logic               unused_in0;
  assign unused_in0 = ^in0[31:1];
  assign take = in0[0];
  // clr_q marks that the previous cycle closed a window, so accumulation restarts from zero.
  assign base_acc = clr_q ? '0 : acc_q;
  assign base_cnt = clr_q ? '0 : cnt_q;
  assign win_end = (period != 16'd0) && (win_q >= period - 16'd1);
  sat_add #(.DATA_W(DATA_W)) u_add (
    .a_i     (base_acc),
    .b_i     (in1),
    .sat_en_i(sat_en),
    .sum_o   (sum)
  );
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    clr_d   = clr_q;
    valid_d = 1'b0;
    if (run) begin
      dly_d   = delay0;
      acc_d   = '0;
      cnt_d   = '0;
      win_d   = '0;
      clr_d   = 1'b0;
      state_d = (delay0 != '0) ? DELAY : ACTIVE;
    end else if (running && state_q == DELAY) begin
      dly_d   = dly_q - DELAY_W'(1);
      state_d = (dly_q <= DELAY_W'(2)) ? ACTIVE : DELAY;
    end else if (running && state_q == ACTIVE) begin
      acc_d   = take ? sum : base_acc;
      cnt_d   = (take && base_cnt != 16'hFFFF) ? base_cnt + 16'd1 : base_cnt;
      win_d   = win_end ? 16'd0 : win_q + 16'd1;
      clr_d   = win_end;
      valid_d = win_end;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dly_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      clr_q   <= clr_d;
      valid_q <= valid_d;
    end
  end
  assign out0  = acc_q;
  assign out1  = cnt_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_cond_accum.sv
// tb_cond_accum: directed stimulus, per-cycle comparison against a behavioural model, plus literal pins.
module tb_cond_accum;
  logic        clk = 1'b0, rst = 1'b0, run = 1'b0, running = 1'b0, sat_en = 1'b0;
  logic [31:0] in0 = '0, in1 = '0, delay0 = '0, out0;
  logic [15:0] period = '0, out1;
  logic        valid;
  int          checks = 0, errors = 0;
  bit          chk_en = 1'b0;

  cond_accum #(.DELAY_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .in0(in0), .in1(in1),
    .delay0(delay0), .period(period), .sat_en(sat_en), .out0(out0), .out1(out1), .valid(valid)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 waiting for first sample, 2 sampling.
  int     m_mode = 0, m_left = 0, m_n = 0, m_w = 0;
  longint m_sum = 0, t;
  bit     m_fresh = 0, m_valid = 0;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_left = 0; m_n = 0; m_w = 0; m_sum = 0; m_fresh = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (run) begin
        m_sum = 0; m_n = 0; m_w = 0; m_fresh = 0;
        m_left = int'(delay0);
        m_mode = (delay0 == 0) ? 2 : 1;
      end else if (running && m_mode == 1) begin
        m_left = m_left - 1;
        if (m_left <= 1) m_mode = 2;
      end else if (running && m_mode == 2) begin
        if (m_fresh) begin m_sum = 0; m_n = 0; m_fresh = 0; end
        if (in0[0]) begin
          t = m_sum + longint'($signed(in1));
          if (sat_en) t = (t > MAXV) ? MAXV : (t < MINV) ? MINV : t;
          m_sum = longint'(int'(t));
          m_n = (m_n < 65535) ? m_n + 1 : 65535;
        end
        m_w = m_w + 1;
        if (period != 0 && m_w >= int'(period)) begin
          m_valid = 1; m_fresh = 1; m_w = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out0", out0, m_sum[31:0]);
      chk("model_out1", {16'd0, out1}, m_n);
      chk("model_valid", {31'd0, valid}, {31'd0, m_valid});
    end
  end

  task automatic cyc(input logic r, input logic rn, input logic c, input logic [31:0] d);
    run = r; running = rn; in0 = {31'd0, c}; in1 = d;
    @(negedge clk);
  endtask

  int vcount, vfirst;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    chk("reset_out0", out0, 32'd0);
    chk("reset_out1", {16'd0, out1}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);

    // First sample exactly delay0 cycles after run.
    delay0 = 3; period = 0; sat_en = 0;
    cyc(1, 1, 1, 5);
    chk("delay_run", out0, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, 1, 5);
      chk("delay_seq", out0, (i < 3) ? 32'd0 : 32'(5 * (i - 2)));
    end

    // Window of four with a rejected sample.
    delay0 = 0; period = 4;
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 10);
    cyc(0, 1, 0, 99);
    cyc(0, 1, 1, 20);
    chk("win_mid_valid", {31'd0, valid}, 32'd0);
    cyc(0, 1, 1, 30);
    chk("win_out0", out0, 32'd60);
    chk("win_out1", {16'd0, out1}, 32'd3);
    chk("win_valid", {31'd0, valid}, 32'd1);
    cyc(0, 1, 0, 7);
    chk("win_next_out0", out0, 32'd0);
    chk("win_next_valid", {31'd0, valid}, 32'd0);
    cyc(0, 1, 1, 7);
    chk("win_next_acc", out0, 32'd7);

    // Saturation vs wrap at both ends.
    period = 0; sat_en = 1;
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h7FFFFFF0);
    cyc(0, 1, 1, 32'h100);
    chk("sat_pos", out0, 32'h7FFFFFFF);
    sat_en = 0;
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h7FFFFFF0);
    cyc(0, 1, 1, 32'h100);
    chk("wrap_pos", out0, 32'h800000F0);
    sat_en = 1;
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h80000010);
    cyc(0, 1, 1, 32'hFFFFFF00);
    chk("sat_neg", out0, 32'h80000000);
    sat_en = 0;

    // running low freezes DELAY and ACTIVE.
    delay0 = 3;
    cyc(1, 1, 1, 5);
    cyc(0, 1, 1, 5);
    repeat (5) cyc(0, 0, 1, 5);
    chk("freeze_delay", out0, 32'd0);
    cyc(0, 1, 1, 5);
    chk("freeze_pre", out0, 32'd0);
    cyc(0, 1, 1, 5);
    chk("freeze_first", out0, 32'd5);
    repeat (5) cyc(0, 0, 1, 5);
    chk("freeze_active", out0, 32'd5);
    cyc(0, 1, 1, 5);
    chk("freeze_resume", out0, 32'd10);

    // Re-run mid-window aborts it without a valid pulse.
    delay0 = 0; period = 8;
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 40);
    cyc(0, 1, 1, 2);
    chk("abort_acc", out0, 32'd42);
    delay0 = 2;
    cyc(1, 1, 1, 5);
    chk("abort_clear", out0, 32'd0);
    chk("abort_valid0", {31'd0, valid}, 32'd0);
    vcount = 0; vfirst = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, 0, 0);
      if (valid) begin
        vcount++;
        if (vfirst == 0) vfirst = i;
      end
    end
    chk("abort_vcount", vcount, 32'd1);
    chk("abort_vfirst", vfirst, 32'd9);

    // Asynchronous reset mid-window.
    delay0 = 0; period = 4;
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 3);
    cyc(0, 1, 1, 3);
    chk("prerst_out0", out0, 32'd6);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_out0", out0, 32'd0);
    chk("arst_out1", {16'd0, out1}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 9);
      chk("idle_out0", out0, 32'd0);
      chk("idle_out1", {16'd0, out1}, 32'd0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
